// File: rtl/instruction_block_memory.sv
// Block-wide instruction memory: word-addressed program load, fixed-latency block reads.
// One bank per word lane so every lane reads its word of the block in parallel.
module instruction_block_memory #(
  parameter int ADDR_WIDTH      = 6,
  parameter int WORDS_PER_BLOCK = 4,
  parameter int READ_LATENCY    = 5
) (
  input  logic                                               CLK,
  input  logic                                               RESET,
  input  logic                                               READ,
  input  logic [ADDR_WIDTH-1:0]                              ADDRESS,
  input  logic                                               WRITE,
  input  logic [ADDR_WIDTH+$clog2(WORDS_PER_BLOCK)-1:0]      WRITE_ADDR,
  input  logic [31:0]                                        WRITEDATA,
  output logic [32*WORDS_PER_BLOCK-1:0]                      READINST,
  output logic                                               BUSYWAIT
);

  localparam int WORD_BITS         = $clog2(WORDS_PER_BLOCK);
  localparam int NUM_BLOCKS        = 1 << ADDR_WIDTH;
  localparam int SEL_W             = (WORD_BITS > 0) ? WORD_BITS : 1;
  localparam logic [7:0] LAT_INIT  = 8'(READ_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                  state_q, state_d;
  logic [7:0]              cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [ADDR_WIDTH-1:0]   load_addr;
  logic                    load_en;
  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   wr_block;
  logic [SEL_W-1:0]        wr_word;

  // Upper word-address bits pick the block, lower bits pick the lane (bank).
  if (WORD_BITS == 0) begin : g_one_word
    assign wr_block = WRITE_ADDR;
    assign wr_word  = '0;
  end else begin : g_multi_word
    assign wr_block = WRITE_ADDR[ADDR_WIDTH+WORD_BITS-1:WORD_BITS];
    assign wr_word  = WRITE_ADDR[WORD_BITS-1:0];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    load_en   = 1'b0;
    load_addr = addr_q;
    case (state_q)
      IDLE: begin
        if (READ && !WRITE) begin
          addr_d = ADDRESS;
          if (READ_LATENCY == 1) begin
            load_en   = 1'b1;
            load_addr = ADDRESS;
            state_d   = DONE;
          end else begin
            cnt_d   = LAT_INIT;
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (cnt_q == 8'd0) begin
          load_en = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
    end
  end

  assign BUSYWAIT = ((state_q == IDLE) && READ) || (state_q == BUSY);
  assign mem_we   = WRITE && !RESET && (state_q != BUSY);

  // Word w of the byte image lives in lane w%WORDS_PER_BLOCK, row w/WORDS_PER_BLOCK,
  // LSB in the lowest byte, so the little-endian image maps straight onto 32-bit rows.
  genvar gi;
  for (gi = 0; gi < WORDS_PER_BLOCK; gi++) begin : g_bank
    logic [31:0] bank_mem [NUM_BLOCKS];
    logic [31:0] rd_word_q;

    always_ff @(posedge CLK) begin
      if (mem_we && (wr_word == SEL_W'(gi))) begin
        bank_mem[wr_block] <= WRITEDATA;
      end
    end

    always_ff @(posedge CLK) begin
      if (RESET) begin
        rd_word_q <= '0;
      end else if (load_en) begin
        rd_word_q <= bank_mem[load_addr];
      end
    end

    assign READINST[32*gi +: 32] = rd_word_q;
  end

endmodule

// File: tb/tb_instruction_block_memory.sv
// Directed bench: default instance (latency 5, 4 words) plus a latency-1, 8-word instance.
module tb_instruction_block_memory;

  logic         clk;
  logic         a_reset, a_read, a_write;
  logic [5:0]   a_address;
  logic [7:0]   a_waddr;
  logic [31:0]  a_wdata;
  logic [127:0] a_readinst;
  logic         a_busy;

  logic         b_reset, b_read, b_write;
  logic [5:0]   b_address;
  logic [8:0]   b_waddr;
  logic [31:0]  b_wdata;
  logic [255:0] b_readinst;
  logic         b_busy;

  int errors = 0;
  int checks = 0;

  localparam logic [127:0] BLK0   = 128'h00000004_00000003_00000002_00000001;
  localparam logic [127:0] BLK1   = 128'h00000008_00000007_00000006_00000005;
  localparam logic [127:0] BLK1B  = 128'h00000008_00000007_00000006_00000055;
  localparam logic [127:0] BLK2   = 128'h0000000C_0000000B_BBBB0009_AAAA0008;

  instruction_block_memory dut_a (
    .CLK(clk), .RESET(a_reset), .READ(a_read), .ADDRESS(a_address),
    .WRITE(a_write), .WRITE_ADDR(a_waddr), .WRITEDATA(a_wdata),
    .READINST(a_readinst), .BUSYWAIT(a_busy)
  );

  instruction_block_memory #(.ADDR_WIDTH(6), .WORDS_PER_BLOCK(8), .READ_LATENCY(1)) dut_b (
    .CLK(clk), .RESET(b_reset), .READ(b_read), .ADDRESS(b_address),
    .WRITE(b_write), .WRITE_ADDR(b_waddr), .WRITEDATA(b_wdata),
    .READINST(b_readinst), .BUSYWAIT(b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic write_a(input logic [7:0] wa, input logic [31:0] d);
    @(negedge clk);
    a_write = 1'b1; a_waddr = wa; a_wdata = d;
  endtask

  // Issues one read, counts BUSYWAIT-high cycles after acceptance, checks the block.
  task automatic do_read(input string name, input logic [5:0] a, input logic [127:0] exp,
                         input bit wr_in_busy);
    int  n;
    bit  done;
    @(negedge clk);
    a_write = 1'b0; a_read = 1'b1; a_address = a;
    #1;
    checks++;
    if (a_busy !== 1'b1) begin
      errors++; $display("FAIL %s_req_busy: got %b expected 1", name, a_busy);
    end
    @(negedge clk);
    a_read = 1'b0; a_address = ~a;
    n = 0; done = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      #1;
      if (a_busy === 1'b1) n++;
      else done = 1'b1;
      if (!done) begin
        if (wr_in_busy && c == 1) begin
          a_write = 1'b1; a_waddr = 8'd0; a_wdata = 32'hDEADBEEF;
        end else begin
          a_write = 1'b0;
        end
        @(negedge clk);
      end
    end
    a_write = 1'b0;
    checks++;
    if (!done) begin
      errors++; $display("FAIL %s_timeout: busy still high after 20 cycles, expected low", name);
    end
    checks++;
    if (n != 5) begin
      errors++; $display("FAIL %s_busy_cycles: got %0d expected 5", name, n);
    end
    checks++;
    if (a_readinst !== exp) begin
      errors++; $display("FAIL %s_data: got %h expected %h", name, a_readinst, exp);
    end
    $display("read %s addr=%0d busy_cycles=%0d data=%h", name, a, n, a_readinst);
  endtask

  task automatic test_reset;
    @(negedge clk);
    a_reset = 1'b1; b_reset = 1'b1; a_read = 1'b1;
    #1;
    checks++;
    if (a_busy !== 1'b1) begin
      errors++; $display("FAIL reset_busy_read: got %b expected 1", a_busy);
    end
    @(negedge clk);
    #1;
    checks++;
    if (a_readinst !== '0 || a_busy !== 1'b1) begin
      errors++; $display("FAIL reset_state: got readinst=%h busy=%b expected 0 and 1", a_readinst, a_busy);
    end
    checks++;
    if (b_readinst !== '0) begin
      errors++; $display("FAIL reset_b_readinst: got %h expected 0", b_readinst);
    end
    @(negedge clk);
    a_reset = 1'b0; b_reset = 1'b0; a_read = 1'b0;
    #1;
    checks++;
    if (a_busy !== 1'b0 || a_readinst !== '0) begin
      errors++; $display("FAIL reset_release: got busy=%b readinst=%h expected 0 and 0", a_busy, a_readinst);
    end
    $display("reset done busy=%b readinst=%h", a_busy, a_readinst);
  endtask

  task automatic test_load;
    for (int i = 0; i < 8; i++) write_a(8'(i), 32'(i + 1));
    write_a(8'd10, 32'h0000000B);
    write_a(8'd11, 32'h0000000C);
    @(negedge clk);
    a_write = 1'b0;
    $display("program load words 0-7,10,11 done");
  endtask

  task automatic test_read_hold;
    do_read("blk0", 6'd0, BLK0, 1'b0);
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (a_readinst !== BLK0 || a_busy !== 1'b0) begin
      errors++; $display("FAIL hold_blk0: got %h busy=%b expected %h busy=0", a_readinst, a_busy, BLK0);
    end
    do_read("blk1", 6'd1, BLK1, 1'b0);
  endtask

  task automatic test_back_to_back;
    write_a(8'd4, 32'h00000055);
    do_read("wr_then_rd", 6'd1, BLK1B, 1'b0);
  endtask

  task automatic test_reset_busy;
    @(negedge clk);
    a_read = 1'b1; a_address = 6'd0;
    @(negedge clk);
    a_read = 1'b0;
    repeat (2) @(negedge clk);
    a_reset = 1'b1; a_write = 1'b1; a_waddr = 8'd0; a_wdata = 32'h00000BAD;
    #1;
    checks++;
    if (a_busy !== 1'b1) begin
      errors++; $display("FAIL rstbusy_pre: got busy=%b expected 1", a_busy);
    end
    @(negedge clk);
    a_reset = 1'b0; a_write = 1'b0;
    #1;
    checks++;
    if (a_readinst !== '0 || a_busy !== 1'b0) begin
      errors++; $display("FAIL rstbusy_abort: got readinst=%h busy=%b expected 0 busy=0", a_readinst, a_busy);
    end
    repeat (6) @(negedge clk);
    #1;
    checks++;
    if (a_readinst !== '0 || a_busy !== 1'b0) begin
      errors++; $display("FAIL rstbusy_no_pending: got readinst=%h busy=%b expected 0 busy=0", a_readinst, a_busy);
    end
    $display("reset during busy readinst=%h", a_readinst);
    do_read("after_rst", 6'd0, BLK0, 1'b0);
  endtask

  task automatic test_write_read_collision;
    @(negedge clk);
    a_write = 1'b1; a_waddr = 8'd8; a_wdata = 32'hAAAA0008; a_read = 1'b1; a_address = 6'd2;
    #1;
    checks++;
    if (a_busy !== 1'b1) begin
      errors++; $display("FAIL coll_busy1: got %b expected 1", a_busy);
    end
    @(negedge clk);
    a_waddr = 8'd9; a_wdata = 32'hBBBB0009;
    #1;
    checks++;
    if (a_busy !== 1'b1) begin
      errors++; $display("FAIL coll_busy2: got %b expected 1 (read must not be accepted)", a_busy);
    end
    $display("write+read held two cycles busy=%b", a_busy);
    do_read("collision", 6'd2, BLK2, 1'b0);
  endtask

  task automatic test_write_during_busy;
    do_read("busy_write", 6'd1, BLK1B, 1'b1);
    do_read("busy_write_chk", 6'd0, BLK0, 1'b0);
  endtask

  task automatic test_latency1_wide;
    logic [255:0] exp0, exp1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      b_write = 1'b1; b_waddr = 9'(i); b_wdata = 32'h100 + 32'(i);
    end
    for (int i = 0; i < 8; i++) begin
      exp0[32*i +: 32] = 32'h100 + 32'(i);
      exp1[32*i +: 32] = 32'h108 + 32'(i);
    end
    @(negedge clk);
    b_write = 1'b0; b_read = 1'b1; b_address = 6'd0;
    #1;
    checks++;
    if (b_busy !== 1'b1) begin
      errors++; $display("FAIL l1_req0_busy: got %b expected 1", b_busy);
    end
    @(negedge clk);
    b_address = 6'd1;
    #1;
    checks++;
    if (b_busy !== 1'b0 || b_readinst !== exp0) begin
      errors++; $display("FAIL l1_done0: got busy=%b data=%h expected busy=0 data=%h", b_busy, b_readinst, exp0);
    end
    $display("latency1 read blk0 data=%h", b_readinst);
    @(negedge clk);
    #1;
    checks++;
    if (b_busy !== 1'b1 || b_readinst !== exp0) begin
      errors++; $display("FAIL l1_idle_req1: got busy=%b data=%h expected busy=1 data=%h", b_busy, b_readinst, exp0);
    end
    @(negedge clk);
    #1;
    checks++;
    if (b_busy !== 1'b0 || b_readinst !== exp1) begin
      errors++; $display("FAIL l1_done1: got busy=%b data=%h expected busy=0 data=%h", b_busy, b_readinst, exp1);
    end
    $display("latency1 read blk1 data=%h", b_readinst);
    b_read = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (b_busy !== 1'b0 || b_readinst !== exp1) begin
      errors++; $display("FAIL l1_hold: got busy=%b data=%h expected busy=0 data=%h", b_busy, b_readinst, exp1);
    end
  endtask

  initial begin
    a_reset = 1'b1; a_read = 1'b0; a_write = 1'b0; a_address = '0; a_waddr = '0; a_wdata = '0;
    b_reset = 1'b1; b_read = 1'b0; b_write = 1'b0; b_address = '0; b_waddr = '0; b_wdata = '0;
    test_reset();
    test_load();
    test_read_hold();
    test_back_to_back();
    test_reset_busy();
    test_write_read_collision();
    test_write_during_busy();
    test_latency1_wide();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instruction_block_memory.md
INSTRUCTION_BLOCK_MEMORY -- requirements
Module: instruction_block_memory

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 6, meaning width of the block address; there are 2^ADDR_WIDTH blocks.
REQ-002 The block SHALL have parameter WORDS_PER_BLOCK, default 4, meaning 32-bit words per block; it is a power of 2, 1 to 16.
REQ-003 The block SHALL have parameter READ_LATENCY, default 5, meaning clock edges from read acceptance to data valid; it is 1 to 255.
REQ-004 The block SHALL have port CLK, input, 1 bit, meaning the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port RESET, input, 1 bit, meaning the reset, synchronous and active-high.
REQ-006 The block SHALL have port READ, input, 1 bit, meaning a block read request.
REQ-007 The block SHALL have port ADDRESS, input, ADDR_WIDTH bits, meaning the block address of the read.
REQ-008 The block SHALL have port WRITE, input, 1 bit, meaning a program-load word write strobe.
REQ-009 The block SHALL have port WRITE_ADDR, input, ADDR_WIDTH+log2(WORDS_PER_BLOCK) bits, meaning the word address of the write.
REQ-010 The block SHALL have port WRITEDATA, input, 32 bits, meaning the instruction word to store.
REQ-011 The block SHALL have port READINST, output, 32*WORDS_PER_BLOCK bits, meaning the returned block.
REQ-012 The block SHALL have port BUSYWAIT, output, 1 bit, meaning a stall request to the requester.

Function
REQ-013 Storage SHALL be 2^ADDR_WIDTH*WORDS_PER_BLOCK*4 bytes, little-endian: word w occupies bytes 4w..4w+3, with the LSB at the lowest byte.
REQ-014 READINST bits [32i+31:32i] SHALL hold word {latched ADDRESS, i} for i = 0..WORDS_PER_BLOCK-1.
REQ-015 The FSM SHALL have three states: IDLE, BUSY, DONE.
REQ-016 In IDLE with READ=1 and WRITE=0, the block SHALL latch ADDRESS, load the latency counter with READ_LATENCY-1, and go to BUSY (READ_LATENCY=1: go directly to DONE and update READINST on the same edge).
REQ-017 In BUSY, the counter SHALL decrement each edge; at the edge where the counter is 0, READINST SHALL be loaded from the latched address and the state SHALL go to DONE.
REQ-018 The state SHALL go from DONE to IDLE unconditionally after one cycle; READ is not sampled in DONE, so a new request is accepted at the earliest in the following IDLE cycle.
REQ-019 BUSYWAIT SHALL be combinational: 1 when (state=IDLE and READ=1) or state=BUSY, else 0; in DONE it is 0 and READINST is valid.
REQ-020 Net read latency SHALL be: request accepted at edge k, READINST valid after edge k+READ_LATENCY, BUSYWAIT low in the cycle following that edge.
REQ-021 READINST SHALL hold its value until the next read completes or a reset occurs.
REQ-022 ADDRESS changes and READ deassertion during BUSY SHALL be ignored; an accepted read always completes.
REQ-023 WRITE=1 in IDLE or DONE SHALL store WRITEDATA at WRITE_ADDR on that edge.
REQ-024 WRITE=1 in BUSY SHALL be ignored, with no memory change.
REQ-025 With WRITE=1 and READ=1 in IDLE, the write SHALL take effect and the read SHALL not be accepted that edge; BUSYWAIT=1 and the read is accepted on a later IDLE edge once WRITE=0.
REQ-026 A read accepted on the edge after a write to the same block SHALL return the new word.
REQ-027 The counter SHALL be 8 bits and never wrap below 0.

Reset
REQ-028 With RESET=1 at an edge, the state SHALL go to IDLE, the counter to 0, and READINST to all zeros; BUSYWAIT then follows REQ-019 (READ=1 during reset gives BUSYWAIT=1, with no acceptance while RESET=1).
REQ-029 Reset during BUSY SHALL abort the read, leave READINST at zero, and leave no pending transaction.
REQ-030 Memory contents SHALL NOT be cleared by reset; writes with RESET=1 SHALL be ignored.

Verification
REQ-031 With defaults: write words 0-4 with 0x01 through 0x05 after reset, then read ADDRESS=0 -> BUSYWAIT high for exactly 5 cycles; READINST = 0x00000004_00000003_00000002_00000001.
REQ-032 Read ADDRESS=1 -> READINST[31:0] = 0x00000005 and all other words equal to their loaded values; READINST is unchanged in the cycles between reads.
REQ-033 Assert RESET during the 3rd BUSY cycle -> READINST = 0 and state IDLE on the next cycle; a re-issued read of ADDRESS=0 returns the original data after 5 edges.
REQ-034 Hold WRITE and READ together for 2 cycles in IDLE -> both words written, BUSYWAIT=1 throughout, and the read accepted on the first edge with WRITE=0.
REQ-035 Pulse WRITE to word 0 with 0xDEADBEEF during BUSY -> memory unchanged, and a subsequent read returns 0x00000001 in word 0.
REQ-036 With READ_LATENCY=1 and WORDS_PER_BLOCK=8: back-to-back reads of blocks 0 and 1 -> each returns after 1 edge, DONE lasts 1 cycle, and READINST is 256 bits wide.
